pc_predict_unit: RTL
====================

PC_PREDICT_UNIT -- requirements
Module: pc_predict_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning PC/address width in bits.
REQ-002 SHALL have parameter BTB_DEPTH, default 8, meaning BTB entry count; power of two, at least 2.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC value loaded on reset.
REQ-004 SHALL have: clk  in  1  system clock; all state updates on negedge clk.
REQ-005 SHALL have: rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have: pc_keep  in  1  stall; hold pc.
REQ-007 SHALL have: redirect  in  1  misprediction detected; load redirect_pc.
REQ-008 SHALL have: redirect_pc  in  WIDTH  corrected fetch address.
REQ-009 SHALL have: upd_valid  in  1  a branch resolved this cycle.
REQ-010 SHALL have: upd_pc  in  WIDTH  address of the resolved branch.
REQ-011 SHALL have: upd_taken  in  1  actual branch outcome.
REQ-012 SHALL have: upd_target  in  WIDTH  actual taken target.
REQ-013 SHALL have: btb_flush  in  1  invalidate all BTB entries.
REQ-014 SHALL have: pc  out  WIDTH  current fetch address, registered.
REQ-015 SHALL have: pred_taken  out  1  combinational prediction for the current pc.
REQ-016 SHALL have: pred_target  out  WIDTH  combinational next pc as predicted: the BTB target if taken, else pc+1.

Function
REQ-017 SHALL select the next pc by priority redirect > pc_keep > prediction; a redirect is never lost during a stall.
REQ-018 SHALL treat the BTB as direct-mapped: index = pc[IDX-1:0], tag = pc[WIDTH-1:IDX], IDX = log2(BTB_DEPTH).
REQ-019 SHALL store per entry: valid, tag, target, and a 2-bit saturating counter.
REQ-020 SHALL assert pred_taken when the indexed entry is valid, its tag matches, and counter >= 2.
REQ-021 SHALL compute pc+1 modulo 2^WIDTH, wrapping from all-ones to 0.
REQ-022 SHALL apply the following on an update hit (valid entry and tag match): taken increments the counter, saturating at 3, and writes the target; not-taken decrements the counter, saturating at 0.
REQ-023 SHALL allocate on an update miss with upd_taken=1: valid=1, new tag, target=upd_target, counter=2; a miss with upd_taken=0 changes nothing.
REQ-024 SHALL make BTB writes effective at the same edge as the pc update, with no read bypass; same-cycle lookup sees old contents.
REQ-025 SHALL let btb_flush clear all valid bits at the edge; flush wins over a simultaneous update.
REQ-026 SHALL keep update and pc_keep independent; the BTB updates even while pc is held.

Reset
REQ-027 SHALL on rst=0 immediately set pc=RESET_PC, clear all valid bits, and set all counters to 1, regardless of clk.
REQ-028 SHALL resume normal operation on the first negedge after rst releases; an update presented during reset is discarded.

Structure
REQ-029 SHALL keep counter encodings (SNT=0, WNT=1, WT=2, ST=3) and the allocation value in a shared package, pc_pkg.
REQ-030 SHALL implement storage and lookup as one sub-module, btb_dm, instantiated once; the pc register and selection logic stay in the top level.

Verification
REQ-031 SHALL verify reset mid-run: with pc=0x0025, drive rst=0 -> pc=0x0000 at once, pred_taken=0 for all indices.
REQ-032 SHALL verify sequential fetch: cycle from reset with no updates -> pc steps 0,1,2,3; at pc=0xFFFF the next pc is 0x0000.
REQ-033 SHALL verify allocation: upd pc=0x0004, taken, target=0x0040 -> next visit to 0x0004 gives pred_taken=1 and next pc 0x0040.
REQ-034 SHALL verify hysteresis: after REQ-033, two not-taken updates at 0x0004 -> counter reaches 0 and pred_taken=0; one taken update -> still 0.
REQ-035 SHALL verify priority: redirect=1 with pc_keep=1 and redirect_pc=0x0100 -> pc=0x0100; pc_keep alone -> pc holds.
REQ-036 SHALL verify aliasing and flush: entry set at 0x0004, lookup at 0x000C (same index, different tag) -> no hit; btb_flush with a simultaneous update -> all entries invalid.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the PC prediction unit: 2-bit branch counter encodings
// and the saturating counter update helpers.
package pc_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt_e;

  localparam cnt_e CNT_ALLOC     = WT;
  localparam cnt_e CNT_RESET     = WNT;
  localparam cnt_e CNT_TAKEN_MIN = WT;

  function automatic cnt_e cnt_inc(input cnt_e c);
    return (c == ST) ? ST : cnt_e'(c + 2'd1);
  endfunction

  function automatic cnt_e cnt_dec(input cnt_e c);
    return (c == SNT) ? SNT : cnt_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/pc_predict_unit_if.sv
// Fetch-side bus of the PC prediction unit: pc control, branch resolution
// updates from the back end, and the registered pc / prediction outputs.
interface pc_predict_unit_if #(
  parameter int WIDTH = 16
);
  logic             pc_keep;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             upd_valid;
  logic [WIDTH-1:0] upd_pc;
  logic             upd_taken;
  logic [WIDTH-1:0] upd_target;
  logic             btb_flush;
  logic [WIDTH-1:0] pc;
  logic             pred_taken;
  logic [WIDTH-1:0] pred_target;

  modport master (
    output pc_keep, redirect, redirect_pc, upd_valid, upd_pc, upd_taken,
           upd_target, btb_flush,
    input  pc, pred_taken, pred_target
  );

  modport slave (
    input  pc_keep, redirect, redirect_pc, upd_valid, upd_pc, upd_taken,
           upd_target, btb_flush,
    output pc, pred_taken, pred_target
  );
endinterface

// File: rtl/pc_predict_unit_btb_dm.sv
// Direct-mapped branch target buffer: combinational lookup of the fetch pc and
// negedge-clocked update/allocate/flush with no read bypass.
module btb_dm
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lookup_pc_i,
  output logic             pred_taken_o,
  output logic [WIDTH-1:0] pred_target_o,
  input  logic             upd_valid_i,
  input  logic [WIDTH-1:0] upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [WIDTH-1:0] upd_target_i,
  input  logic             flush_i
);
  localparam int IDX   = $clog2(DEPTH);
  localparam int TAG_W = WIDTH - IDX;

  logic             valid_q [DEPTH];
  cnt_e             cnt_q   [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [WIDTH-1:0] tgt_q   [DEPTH];

  logic [IDX-1:0]   rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             upd_hit;

  assign rd_idx = lookup_pc_i[IDX-1:0];
  assign rd_tag = lookup_pc_i[WIDTH-1:IDX];
  assign wr_idx = upd_pc_i[IDX-1:0];
  assign wr_tag = upd_pc_i[WIDTH-1:IDX];

  assign pred_taken_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) &&
                         (cnt_q[rd_idx] >= CNT_TAKEN_MIN);
  assign pred_target_o = tgt_q[rd_idx];
  assign upd_hit       = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_RESET;
      end
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        cnt_q[wr_idx] <= upd_taken_i ? cnt_inc(cnt_q[wr_idx]) : cnt_dec(cnt_q[wr_idx]);
      end else if (upd_taken_i) begin
        valid_q[wr_idx] <= 1'b1;
        cnt_q[wr_idx]   <= CNT_ALLOC;
      end
    end
  end

  // NOTE: tag/target storage has no reset; an entry is only ever read through
  // its valid bit, so clearing valid is enough and keeps the arrays plain RAM.
  always_ff @(negedge clk) begin
    if (!flush_i && upd_valid_i && upd_taken_i) begin
      tag_q[wr_idx] <= wr_tag;
      tgt_q[wr_idx] <= upd_target_i;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch pc register with next-pc selection (redirect > stall > prediction)
// around a single direct-mapped BTB.
module pc_predict_unit #(
  parameter int               WIDTH     = 16,
  parameter int               BTB_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input logic               clk,
  input logic               rst,
  pc_predict_unit_if.slave  bus
);
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] btb_target;
  logic             btb_taken;
  logic [WIDTH-1:0] pred_target;

  btb_dm #(
    .WIDTH (WIDTH),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc_i   (pc_q),
    .pred_taken_o  (btb_taken),
    .pred_target_o (btb_target),
    .upd_valid_i   (bus.upd_valid),
    .upd_pc_i      (bus.upd_pc),
    .upd_taken_i   (bus.upd_taken),
    .upd_target_i  (bus.upd_target),
    .flush_i       (bus.btb_flush)
  );

  // Natural width wrap takes all-ones back to zero.
  assign pc_plus1    = pc_q + WIDTH'(1);
  assign pred_target = btb_taken ? btb_target : pc_plus1;

  always_comb begin
    pc_d = pred_target;
    if (bus.redirect)     pc_d = bus.redirect_pc;
    else if (bus.pc_keep) pc_d = pc_q;
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  assign bus.pc          = pc_q;
  assign bus.pred_taken  = btb_taken;
  assign bus.pred_target = pred_target;

endmodule
